// File: rtl/seg7_scan_controller_pkg.sv
// Shared definitions for the 7-segment scan controller and the encoder it feeds.
// CODE_W matches the width of the shared encoder's switch input.
package seg7_scan_controller_pkg;

    localparam int CODE_W = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } scan_state_e;

endpackage

// File: rtl/seg7_slot_timer.sv
// Per-digit slot counter: counts 0..SLOT_CYCLES-1 while run is high, clears when low.
// Strobes mark the last blank cycle, the cycle before slot end, and the slot end.
module seg7_slot_timer #(
    parameter int SLOT_CYCLES  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic blank_end,
    output logic slot_almost_end,
    output logic slot_end
);

    localparam int CNT_W = $clog2(SLOT_CYCLES);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = '0;
        if (run) begin
            cnt_d = (cnt_q == CNT_W'(SLOT_CYCLES - 1)) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign blank_end       = run && (cnt_q == CNT_W'(BLANK_CYCLES - 1));
    assign slot_almost_end = run && (cnt_q == CNT_W'(SLOT_CYCLES - 2));
    assign slot_end        = run && (cnt_q == CNT_W'(SLOT_CYCLES - 1));

endmodule

// File: rtl/seg7_scan_controller.sv
// Time-multiplexed scan of NUM_DIGITS common-anode digits through one shared encoder,
// with frame-aligned loading of new display contents via a valid/ready handshake.
module seg7_scan_controller
    import seg7_scan_controller_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SLOT_CYCLES  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         enable,
    input  logic                         load_valid,
    input  logic [CODE_W*NUM_DIGITS-1:0] load_data,
    output logic                         load_ready,
    output logic [CODE_W-1:0]            code,
    output logic [NUM_DIGITS-1:0]        an,
    output logic                         frame_done
);

    localparam int                IDX_W    = $clog2(NUM_DIGITS);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    scan_state_e                  state_q, state_d;
    logic [IDX_W-1:0]             idx_q, idx_d;
    logic [CODE_W*NUM_DIGITS-1:0] display_q, display_d;
    logic [CODE_W*NUM_DIGITS-1:0] pending_q, pending_d;
    logic                         pending_vld_q, pending_vld_d;
    logic                         load_ready_q, load_ready_d;
    logic [CODE_W-1:0]            code_q, code_d;
    logic [NUM_DIGITS-1:0]        an_q, an_d;
    logic                         frame_done_q, frame_done_d;

    logic run;
    logic blank_end;
    logic slot_almost_end;
    logic slot_end;
    logic apply;

    assign run = enable && (state_q != IDLE);

    seg7_slot_timer #(
        .SLOT_CYCLES  (SLOT_CYCLES),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_slot_timer (
        .clk             (clk),
        .rst_n           (rst_n),
        .run             (run),
        .blank_end       (blank_end),
        .slot_almost_end (slot_almost_end),
        .slot_end        (slot_end)
    );

    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        display_d     = display_q;
        pending_d     = pending_q;
        pending_vld_d = pending_vld_q;
        code_d        = code_q;

        unique case (state_q)
            IDLE:  if (enable) state_d = BLANK;
            BLANK: begin
                if (!enable)        state_d = IDLE;
                else if (blank_end) state_d = SHOW;
            end
            SHOW: begin
                if (!enable) begin
                    state_d = IDLE;
                end else if (slot_end) begin
                    state_d = BLANK;
                    idx_d   = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        if (!enable) idx_d = '0;

        // Frame boundary while scanning, or any time the scan is parked in IDLE.
        apply = pending_vld_q && ((frame_done_q && enable) || (state_q == IDLE));
        if (apply) begin
            display_d     = pending_q;
            pending_vld_d = 1'b0;
        end
        if (load_valid && load_ready_q) begin
            pending_d     = load_data;
            pending_vld_d = 1'b1;
        end

        if ((state_d == BLANK && state_q != BLANK) || (state_q == IDLE && apply)) begin
            code_d = display_d[int'(idx_d)*CODE_W +: CODE_W];
        end

        an_d         = (state_d == SHOW) ? ~(NUM_DIGITS'(1) << idx_d) : '1;
        frame_done_d = slot_almost_end && (idx_q == LAST_IDX);
        load_ready_d = !pending_vld_d;
    end

    // NOTE: display and pending are ordinary registers, so they take the async reset too.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            display_q     <= '0;
            pending_q     <= '0;
            pending_vld_q <= 1'b0;
            load_ready_q  <= 1'b1;
            code_q        <= '0;
            an_q          <= '1;
            frame_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            display_q     <= display_d;
            pending_q     <= pending_d;
            pending_vld_q <= pending_vld_d;
            load_ready_q  <= load_ready_d;
            code_q        <= code_d;
            an_q          <= an_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign load_ready = load_ready_q;
    assign code       = code_q;
    assign an         = an_q;
    assign frame_done = frame_done_q;

endmodule

// File: doc/seg7_scan_controller.md
# seg7_scan_controller

Time-multiplexing scheduler that shares the single switch-code-to-7-segment encoder across NUM_DIGITS common-anode digits. Holds one 5-bit code per digit, presents them in turn on the encoder's `code` input and drives the matching active-low anode, with a blanking gap between digits against ghosting. New display contents are loaded through a valid/ready handshake and take effect only at a frame boundary, so a frame never mixes old and new digits.

## Interface
- NUM_DIGITS, 4: digits scanned per frame (2..8)
- SLOT_CYCLES, 50000: clk cycles per digit slot (blank + show)
- BLANK_CYCLES, 500: cycles at start of each slot with all anodes off; 1 <= BLANK_CYCLES < SLOT_CYCLES
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- enable  in  1  scan on when high; all anodes off when low
- load_valid  in  1  load request
- load_data  in  5*NUM_DIGITS  digit codes; digit i = bits [5i+4:5i]
- load_ready  out  1  high when a load can be accepted
- code  out  5  code for the shared encoder's switch input
- an  out  NUM_DIGITS  anode enables, active-low, one-hot-low or all ones
- frame_done  out  1  one-cycle pulse at end of last digit's slot

## Operation
- Reset (async, rst_n low): state IDLE, an all ones, code 0, load_ready 1, frame_done 0, display and pending registers 0, pending flag 0, slot counter 0, digit index 0.
- States:
  - IDLE: an all ones, counter and index held at 0. enable=1 → BLANK.
  - BLANK: an all ones, code = display[idx]. After BLANK_CYCLES cycles → SHOW.
  - SHOW: an[idx]=0, others 1. After SLOT_CYCLES-BLANK_CYCLES cycles → BLANK with idx+1. From idx NUM_DIGITS-1, idx wraps to 0 and frame_done pulses in the last SHOW cycle.
  - enable=0 in any state → IDLE next cycle. idx and counter reset, so a re-enabled scan restarts at digit 0.
- Load handshake: transfer when load_valid && load_ready. Data is captured into the pending register, the pending flag is set and load_ready drops the next cycle.
- Pending apply:
  - With enable high, pending is copied to display on the frame_done cycle. The pending flag clears, and load_ready rises the following cycle.
  - In IDLE, pending is applied the cycle after capture.
- A load accepted on the frame_done cycle (no prior pending) is applied at the next frame boundary, not the current one.
- code never changes while any anode is low. It updates only at BLANK entry, or on display update while IDLE.
- Counter width: $clog2(SLOT_CYCLES). The counter counts 0..SLOT_CYCLES-1 per slot and wraps to 0.

## Timing
- All outputs registered; no combinational input→output paths.
- enable rise at cycle t: BLANK from t+1. an[0] low from t+1+BLANK_CYCLES.
- Frame period with enable held high: NUM_DIGITS*SLOT_CYCLES cycles. frame_done period is identical.
- Load capture at t with scan running: new codes are visible on `code` at the first BLANK after the next frame_done.
- enable fall at t: an all ones at t+1.
- rst_n assertion mid-frame: outputs reach reset values immediately, with no clock edge required.
- Deassertion is synchronised externally. The first active edge after release behaves as IDLE.

## Structure
- Shared package: state encoding (IDLE, BLANK, SHOW) and constant CODE_W=5, shared with the encoder's switch width.
- One sub-module, `seg7_slot_timer`: slot counter with blank_end and slot_end strobes, parameterised by SLOT_CYCLES and BLANK_CYCLES.
- FSM, digit index, handshake and pending/display registers live in the top level.
- The shared encoder is instantiated by the parent. This block outputs `code` only.

## Test plan
Bench parameters: NUM_DIGITS=4, SLOT_CYCLES=8, BLANK_CYCLES=2.
- **Reset mid-scan.** Pull rst_n low during SHOW of digit 2 → an=4'b1111, code=0, load_ready=1 within the same cycle, with no clock edge needed.
- **Load in IDLE, then scan.** With enable=0, load codes 1,2,3,4 (digits 0..3), then raise enable → each digit shows its code in sequence:
  - an sequence 1111×2, 1110×6, 1111×2, 1101×6, …
  - code 1,2,3,4 while its anode is low
  - frame_done every 32 cycles
- **Mid-frame load.** While scanning, load 5,0,1,2 mid-frame → load_ready low until the cycle after frame_done. The current frame still shows 1,2,3,4; the next frame shows 5,0,1,2.
- **Load on frame boundary.** Present load_valid exactly on the frame_done cycle with nothing pending → accepted. The codes appear one frame later, not immediately.
- **Enable toggle mid-frame.** Drop enable during SHOW of digit 1 → an=1111 next cycle. Re-enable → BLANK at digit 0; an[0] low 2 cycles later.
- **Handshake hold.** Hold load_valid high for 40 cycles while scanning → exactly one transfer per frame boundary. No data is lost or duplicated, checked against a scoreboard.
